// File: rtl/seg_scan_if.sv
// Host/display bus for seg_scan_ctrl: digit-register writes in, scan outputs out.
interface seg_scan_if #(
  parameter int NDIG = 4
);
  logic            en;
  logic            wr;
  logic [2:0]      waddr;
  logic [3:0]      wdata;
  logic [6:0]      seg;
  logic [NDIG-1:0] an;
  logic            frame;

  modport master (output en, wr, waddr, wdata, input seg, an, frame);
  modport slave  (input en, wr, waddr, wdata, output seg, an, frame);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Round-robin seven-segment scan controller with one shared BCD decoder and blank guard slots.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LEAD_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DWELL = 1000,
  parameter int GUARD = 4
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);
  localparam int CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NDIG);

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);
  localparam logic [NDIG-1:0]  AN_ONE     = NDIG'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GUARD,
    ST_SHOW
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg,   idx_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [6:0]       seg_reg,   seg_next;
  logic [NDIG-1:0]  an_reg,    an_next;
  logic             frame_reg, frame_next;
  logic [6:0]       show_seg;

  logic [3:0]       digit_reg [NDIG];
  logic [NDIG-1:0]  digit_zero;
`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
  logic [NDIG-1:0]  lz_blank;
`endif

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000000;
    endcase
  endfunction

  // Writes to an index outside 0..NDIG-1 match no register and are dropped.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          digit_reg[gi] <= 4'd0;
        end else if (bus.wr && (bus.waddr == 3'(gi))) begin
          digit_reg[gi] <= bus.wdata;
        end
      end

      assign digit_zero[gi] = (digit_reg[gi] == 4'd0);

`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
      if (gi == 0) begin : g_lsd
        assign lz_blank[gi] = 1'b0;
      end else if (gi == NDIG - 1) begin : g_msd
        assign lz_blank[gi] = digit_zero[gi];
      end else begin : g_mid
        assign lz_blank[gi] = digit_zero[gi] & (&digit_zero[NDIG-1:gi+1]);
      end
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      seg_reg   <= '0;
      an_reg    <= '0;
      frame_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      seg_reg   <= seg_next;
      an_reg    <= an_next;
      frame_reg <= frame_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    seg_next   = seg_reg;
    an_next    = an_reg;
    frame_next = 1'b0;

    // Segment pattern is snapshotted only on SHOW entry.
    show_seg = decode(digit_reg[idx_reg]);
`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
    if (lz_blank[idx_reg]) begin
      show_seg = 7'b0000000;
    end
`endif

    if (!bus.en) begin
      state_next = ST_IDLE;
      idx_next   = '0;
      cnt_next   = '0;
      seg_next   = '0;
      an_next    = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_GUARD;
          idx_next   = '0;
          cnt_next   = '0;
          seg_next   = '0;
          an_next    = '0;
        end
        ST_GUARD: begin
          if (cnt_reg == GUARD_LAST) begin
            state_next = ST_SHOW;
            cnt_next   = '0;
            seg_next   = show_seg;
            an_next    = AN_ONE << idx_reg;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_reg == DWELL_LAST) begin
            state_next = ST_GUARD;
            cnt_next   = '0;
            seg_next   = '0;
            an_next    = '0;
            if (idx_reg == IDX_LAST) begin
              idx_next   = '0;
              frame_next = 1'b1;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          idx_next   = '0;
          cnt_next   = '0;
          seg_next   = '0;
          an_next    = '0;
        end
      endcase
    end
  end

  assign bus.seg   = seg_reg;
  assign bus.an    = an_reg;
  assign bus.frame = frame_reg;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues expected {an,seg} per digit visit,
// a cycle monitor pops/compares on each SHOW entry and checks guard, dwell and frame timing.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
  localparam int NDIG  = 4;
  localparam int DWELL = 4;
  localparam int GUARD = 2;
  localparam int FRAME_LEN = NDIG * (GUARD + DWELL);

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] SB = 7'b0000000;
`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
  localparam logic [6:0] LZ0 = 7'b0000000;
`else
  localparam logic [6:0] LZ0 = 7'b1111110;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_if #(.NDIG(NDIG)) bus();

  seg_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .GUARD(GUARD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int e0_cycle = 0;
  logic [10:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s);
    exp_q.push_back({a, s});
  endtask

  task automatic write_digit(input logic [2:0] a, input logic [3:0] d);
    @(negedge clk);
    bus.wr    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wr    = 1'b0;
  endtask

  task automatic start_scan();
    @(negedge clk);
    bus.en   = 1'b1;
    e0_cycle = cyc + 1;
  endtask

  task automatic wait_an(input logic [3:0] v, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.an == v) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_an: an never reached %b within %0d cycles (last %b)", v, budget, bus.an);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  logic [3:0] prev_an;
  int rise_cyc, fall_cyc, last_frame;
  bit first_after_idle, have_frame;

  initial begin
    prev_an          = '0;
    rise_cyc         = 0;
    fall_cyc         = 0;
    last_frame       = 0;
    first_after_idle = 1'b1;
    have_frame       = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        first_after_idle = 1'b1;
        have_frame       = 1'b0;
        prev_an          = '0;
        continue;
      end
      if (bus.an == '0) check("seg_blank_when_an_zero", 32'(bus.seg), 32'd0);
      if (prev_an == '0 && bus.an != '0) begin
        $display("show cycle %0d an=%b seg=%b", cyc, bus.an, bus.seg);
        if (exp_q.size() == 0) begin
          check("unexpected_show", 32'(bus.an), 32'd0);
        end else begin
          check("show_entry", 32'({bus.an, bus.seg}), 32'(exp_q.pop_front()));
        end
        if (first_after_idle) check("first_show_latency", 32'(cyc), 32'(e0_cycle + GUARD));
        else                  check("guard_gap", 32'(cyc - fall_cyc), 32'(GUARD));
        check("frame_quiet", 32'(bus.frame), 32'd0);
        first_after_idle = 1'b0;
        rise_cyc = cyc;
      end else if (prev_an != '0 && bus.an == '0) begin
        if (bus.en) check("dwell_hold", 32'(cyc - rise_cyc), 32'(DWELL));
        check("frame_at_wrap", 32'(bus.frame), 32'(bus.en && prev_an == 4'b1000));
        fall_cyc = cyc;
      end else begin
        if (prev_an != '0) check("an_stable_in_show", 32'(bus.an), 32'(prev_an));
        check("frame_quiet", 32'(bus.frame), 32'd0);
      end
      if (bus.frame) begin
        if (have_frame) check("frame_period", 32'(cyc - last_frame), 32'(FRAME_LEN));
        last_frame = cyc;
        have_frame = 1'b1;
      end
      if (!bus.en) begin
        first_after_idle = 1'b1;
        have_frame       = 1'b0;
      end
      prev_an = bus.an;
    end
  end

  initial begin
    rst       = 1'b0;
    bus.en    = 1'b0;
    bus.wr    = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    #2 rst = 1'b1;
    #1;
    check("reset_seg", 32'(bus.seg), 32'd0);
    check("reset_an", 32'(bus.an), 32'd0);
    check("reset_frame", 32'(bus.frame), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full scan, digits 3..0 = 4,3,2,1; mid-dwell writes change frame 2 onward.
    write_digit(3'd0, 4'd1);
    write_digit(3'd1, 4'd2);
    write_digit(3'd2, 4'd3);
    write_digit(3'd3, 4'd4);
    push(4'b0001, S1); push(4'b0010, S2); push(4'b0100, S3); push(4'b1000, S4);
    push(4'b0001, S1); push(4'b0010, SB); push(4'b0100, S8); push(4'b1000, S4);
    push(4'b0001, S1); push(4'b0010, SB);
    start_scan();
    wait_an(4'b0100, 100);
    write_digit(3'd2, 4'd8);
    write_digit(3'd1, 4'd12);
    write_digit(3'd5, 4'd9);
    wait_an(4'b0001, 100);
    wait_an(4'b1000, 100);
    wait_an(4'b0010, 100);

    // Enable drop mid-SHOW of digit 1.
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("en_drop_an", 32'(bus.an), 32'd0);
    check("en_drop_seg", 32'(bus.seg), 32'd0);
    repeat (3) @(negedge clk);
    push(4'b0001, S1); push(4'b0010, SB); push(4'b0100, S8); push(4'b1000, S4);
    start_scan();
    wait_an(4'b1000, 100);
    wait_an(4'b0000, 100);
    bus.en = 1'b0;

    // Leading zeros: digits 3..0 = 0,0,7,0.
    repeat (2) @(negedge clk);
    write_digit(3'd3, 4'd0);
    write_digit(3'd2, 4'd0);
    write_digit(3'd1, 4'd7);
    write_digit(3'd0, 4'd0);
    push(4'b0001, S0); push(4'b0010, S7); push(4'b0100, LZ0); push(4'b1000, LZ0);
    push(4'b0001, S0); push(4'b0010, S7); push(4'b0100, LZ0);
    start_scan();
    wait_an(4'b1000, 100);
    wait_an(4'b0100, 100);

    // Asynchronous reset mid-SHOW, between clock edges.
    #3 rst = 1'b1;
    #1;
    check("midshow_reset_seg", 32'(bus.seg), 32'd0);
    check("midshow_reset_an", 32'(bus.an), 32'd0);
    check("midshow_reset_frame", 32'(bus.frame), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst      = 1'b0;
    e0_cycle = cyc + 1;
    push(4'b0001, S0); push(4'b0010, LZ0); push(4'b0100, LZ0); push(4'b1000, LZ0);
    wait_an(4'b1000, 100);
    wait_an(4'b0000, 100);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
